// File: rtl/memory_bus_pkg.sv
// Shared types and helpers for the hart memory bus: access widths, address
// regions, bus FSM states, and byte-lane strobe/data helpers.
package memory_types;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        width_byte,
        width_halfword,
        width_word
    } access_width_t;

    typedef enum logic [2:0] {
        region_rom,
        region_ram,
        region_in,
        region_out,
        region_none
    } region_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } bus_state_t;

    // Lanes touched by an access of the given width at the given byte offset.
    function automatic logic [3:0] byte_strobe(input access_width_t width,
                                               input logic [1:0] offset);
        case (width)
            width_halfword: return 4'b0011 << {offset[1], 1'b0};
            width_word:     return 4'hF;
            default:        return 4'b0001 << offset;
        endcase
    endfunction

    // Replicate right-aligned store data so every lane the strobe can select
    // already carries the right byte.
    function automatic logic [XLEN-1:0] lane_data(input access_width_t width,
                                                  input logic [XLEN-1:0] wdata);
        case (width)
            width_halfword: return {2{wdata[15:0]}};
            width_word:     return wdata;
            default:        return {4{wdata[7:0]}};
        endcase
    endfunction

    // Force an address down to the natural alignment of its access width.
    function automatic logic [XLEN-1:0] align_addr(input access_width_t width,
                                                   input logic [XLEN-1:0] addr);
        logic [XLEN-1:0] aligned;
        aligned = addr;
        case (width)
            width_halfword: aligned[0]   = 1'b0;
            width_word:     aligned[1:0] = 2'b00;
            default:        ;
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/memory_bus_if.sv
// Request/response handshake between the hart load/store unit (master)
// and the memory bus (slave).
interface memory_bus_if;
    import memory_types::*;

    logic                req_valid;
    logic                req_ready;
    logic [XLEN-1:0]     req_addr;
    logic                req_write;
    access_width_t       req_width;
    logic [XLEN-1:0]     req_wdata;
    logic                resp_valid;
    logic                resp_ready;
    logic [XLEN-1:0]     resp_rdata;
    logic                resp_fault;

    modport master (
        output req_valid, req_addr, req_write, req_width, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_width, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/memory_bus_ram_bytelane.sv
// Word-organised RAM built from four independent byte lanes, each with its
// own write enable; the read of the aligned word is registered.
module ram_bytelane #(
    parameter int RAM_BYTES = 1024,
    parameter int AW        = $clog2(RAM_BYTES) - 2
) (
    input  logic          clock,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    localparam int WORDS = RAM_BYTES / 4;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];
            logic [7:0] rd_reg;

            // One byte lane: write when strobed, capture the read on request.
            always_ff @(posedge clock) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
                if (re) begin
                    rd_reg <= lane_mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = rd_reg;
        end
    endgenerate
endmodule

// File: rtl/memory_bus.sv
// Hart memory bus: decodes ROM / RAM / input / output regions behind a
// valid/ready request and response handshake, inserts ROM wait states,
// performs byte-lane stores and reports faults.
// Build option: define MEMORY_ALIGN_CHECK_EN to fault misaligned halfword
// and word accesses; otherwise such addresses are forced to alignment.
// Stores and RAM/peripheral reads act on the accept edge itself, so the
// response can be presented on the very next cycle.
module memory_bus
    import memory_types::*;
#(
    parameter int              ROM_BYTES         = 2048,
    parameter logic [XLEN-1:0] RAM_BASE          = 32'h0800,
    parameter int              RAM_BYTES         = 1024,
    parameter logic [XLEN-1:0] IN_BASE           = 32'h1000,
    parameter int              INPUT_PERIPH_LEN  = 16,
    parameter logic [XLEN-1:0] OUT_BASE          = 32'h1800,
    parameter int              OUTPUT_PERIPH_LEN = 16,
    parameter int              ROM_WAIT          = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    memory_bus_if.slave                      bus,
    output logic [$clog2(ROM_BYTES)-3:0]     rom_addr,
    input  logic [XLEN-1:0]                  rom_rdata,
    input  logic [8*INPUT_PERIPH_LEN-1:0]    input_periph_mem,
    output logic [8*OUTPUT_PERIPH_LEN-1:0]   output_periph_mem
);
    localparam int ROM_AW    = $clog2(ROM_BYTES) - 2;
    localparam int RAM_AW    = $clog2(RAM_BYTES) - 2;
    localparam int IN_WORDS  = INPUT_PERIPH_LEN / 4;
    localparam int OUT_WORDS = OUTPUT_PERIPH_LEN / 4;
    localparam int IN_IW     = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int OUT_IW    = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    localparam logic [XLEN-1:0] ROM_END   = XLEN'(ROM_BYTES);
    localparam logic [XLEN-1:0] RAM_END   = RAM_BASE + XLEN'(RAM_BYTES);
    localparam logic [XLEN-1:0] IN_END    = IN_BASE + XLEN'(INPUT_PERIPH_LEN);
    localparam logic [XLEN-1:0] OUT_END   = OUT_BASE + XLEN'(OUTPUT_PERIPH_LEN);
    localparam logic [3:0]      WAIT_INIT = 4'(ROM_WAIT);

    bus_state_t        state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic [ROM_AW-1:0] rom_idx_reg;
    logic [XLEN-1:0]   rdata_reg;
    logic              fault_reg;
    logic              from_ram_reg;

    logic              accept;
    logic [XLEN-1:0]   eff_addr;
    logic              align_fault;
    region_t           region;
    logic              fault_now;
    logic              is_rom_read;
    logic              wait_done;
    logic              rom_capture;
    logic [3:0]        strobe;
    logic [XLEN-1:0]   wr_lanes;
    logic [ROM_AW-1:0] rom_idx_now;
    logic [RAM_AW-1:0] ram_idx;
    logic [IN_IW-1:0]  in_idx;
    logic [OUT_IW-1:0] out_idx;
    logic [XLEN-1:0]   read_word;
    logic [3:0]        ram_we;
    logic              ram_re;
    logic [XLEN-1:0]   ram_rdata;
    logic              out_we;
    logic [XLEN-1:0]   in_words  [IN_WORDS];
    logic [XLEN-1:0]   out_words [OUT_WORDS];

    assign accept   = bus.req_valid && (state_reg == S_IDLE);
    assign eff_addr = align_addr(bus.req_width, bus.req_addr);

`ifdef MEMORY_ALIGN_CHECK_EN
    assign align_fault = ((bus.req_width == width_halfword) && bus.req_addr[0]) ||
                         ((bus.req_width == width_word) && (bus.req_addr[1:0] != 2'b00));
`else
    assign align_fault = 1'b0;
`endif

    // Region decode of the effective (aligned) request address.
    always_comb begin
        region = region_none;
        if (eff_addr < ROM_END) begin
            region = region_rom;
        end else if (eff_addr >= RAM_BASE && eff_addr < RAM_END) begin
            region = region_ram;
        end else if (eff_addr >= IN_BASE && eff_addr < IN_END) begin
            region = region_in;
        end else if (eff_addr >= OUT_BASE && eff_addr < OUT_END) begin
            region = region_out;
        end
    end

    assign fault_now   = (region == region_none) || align_fault ||
                         (bus.req_write && (region == region_rom || region == region_in));
    assign is_rom_read = (region == region_rom) && !bus.req_write && !fault_now;
    assign strobe      = byte_strobe(bus.req_width, eff_addr[1:0]);
    assign wr_lanes    = lane_data(bus.req_width, bus.req_wdata);

    assign rom_idx_now = eff_addr[ROM_AW+1:2];
    assign ram_idx     = RAM_AW'((eff_addr - RAM_BASE) >> 2);
    assign in_idx      = IN_IW'((eff_addr - IN_BASE) >> 2);
    assign out_idx     = OUT_IW'((eff_addr - OUT_BASE) >> 2);

    // While idle the ROM sees the live request so a zero-wait read can be
    // captured on the accept edge; afterwards it sees the latched index.
    assign rom_addr = (state_reg == S_IDLE) ? rom_idx_now : rom_idx_reg;

    assign ram_we = (accept && bus.req_write && !fault_now && region == region_ram) ? strobe : 4'b0000;
    assign ram_re = accept && !bus.req_write && !fault_now && (region == region_ram);
    assign out_we = accept && bus.req_write && !fault_now && (region == region_out);

    ram_bytelane #(
        .RAM_BYTES (RAM_BYTES)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_idx),
        .wdata (wr_lanes),
        .rdata (ram_rdata)
    );

    genvar gi;
    generate
        for (gi = 0; gi < IN_WORDS; gi++) begin : g_in_word
            assign in_words[gi] = input_periph_mem[XLEN*gi +: XLEN];
        end

        for (gi = 0; gi < OUT_WORDS; gi++) begin : g_out_word
            assign out_words[gi] = output_periph_mem[XLEN*gi +: XLEN];
        end

        for (gi = 0; gi < OUTPUT_PERIPH_LEN; gi++) begin : g_out_byte
            logic [7:0] byte_reg;

            // Output byte gi sits in word gi/4, lane gi%4; cleared by reset.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    byte_reg <= 8'h00;
                end else if (out_we && out_idx == OUT_IW'(gi / 4) && strobe[gi % 4]) begin
                    byte_reg <= wr_lanes[8*(gi % 4) +: 8];
                end
            end

            assign output_periph_mem[8*gi +: 8] = byte_reg;
        end
    endgenerate

    // Peripheral read word selected at accept time.
    always_comb begin
        read_word = '0;
        case (region)
            region_in:  read_word = in_words[in_idx];
            region_out: read_word = out_words[out_idx];
            default:    ;
        endcase
    end

    assign wait_done   = (wait_cnt_reg <= 4'd1);
    assign rom_capture = (accept && is_rom_read && WAIT_INIT == 4'd0) ||
                         (state_reg == S_WAIT && wait_done);

    // FSM state and ROM wait counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_fault = 1'b0;
        bus.resp_rdata = '0;
        case (state_reg)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) begin
                    if (is_rom_read && WAIT_INIT != 4'd0) begin
                        state_next    = S_WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_next = wait_cnt_reg - 4'd1;
                if (wait_done) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_fault = fault_reg;
                bus.resp_rdata = from_ram_reg ? ram_rdata : rdata_reg;
                if (bus.resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Response payload: latched at accept, ROM data captured when its wait ends.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rom_idx_reg  <= '0;
            rdata_reg    <= '0;
            fault_reg    <= 1'b0;
            from_ram_reg <= 1'b0;
        end else begin
            if (accept) begin
                rom_idx_reg  <= rom_idx_now;
                fault_reg    <= fault_now;
                from_ram_reg <= ram_re;
                rdata_reg    <= (fault_now || bus.req_write) ? '0 : read_word;
            end
            if (rom_capture) begin
                rdata_reg <= rom_rdata;
            end
        end
    end

endmodule

// File: tb/tb_memory_bus.sv
// Self-checking bench for memory_bus: directed cases plus randomized traffic
// checked against a byte-addressed behavioural model of the memory map.
module tb_memory_bus;
    import memory_types::*;

    localparam int ROM_WAIT = 2;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic [8:0]    rom_addr;
    logic [31:0]   rom_rdata;
    logic [127:0]  input_periph_mem;
    logic [127:0]  output_periph_mem;

    logic [31:0]   rom_model [512];
    logic [7:0]    ram_model [1024];
    logic [7:0]    out_model [16];

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    memory_bus_if bus();

    memory_bus dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .bus               (bus),
        .rom_addr          (rom_addr),
        .rom_rdata         (rom_rdata),
        .input_periph_mem  (input_periph_mem),
        .output_periph_mem (output_periph_mem)
    );

    always #5 clock = ~clock;

    assign rom_rdata = rom_model[rom_addr];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] out_packed();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = out_model[i];
        return v;
    endfunction

    // 0 rom, 1 ram, 2 in, 3 out, 4 unmapped
    function automatic int classify(input logic [31:0] a);
        if (a < 32'd2048) return 0;
        if (a >= 32'h0800 && a < 32'h0C00) return 1;
        if (a >= 32'h1000 && a < 32'h1010) return 2;
        if (a >= 32'h1800 && a < 32'h1810) return 3;
        return 4;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        logic [31:0] w;
        case (classify(a))
            0: begin w = rom_model[a >> 2]; return w[8*(a % 4) +: 8]; end
            1: return ram_model[a - 32'h0800];
            2: return input_periph_mem[8*(a - 32'h1000) +: 8];
            3: return out_model[a - 32'h1800];
            default: return 8'h00;
        endcase
    endfunction

    function automatic void wr_byte(input logic [31:0] a, input logic [7:0] d);
        case (classify(a))
            1: ram_model[a - 32'h0800] = d;
            3: out_model[a - 32'h1800] = d;
            default: ;
        endcase
    endfunction

    // Expected outcome of one access; applies its effect to the model.
    function automatic void model_access(input logic [31:0] addr, input logic wr,
                                         input access_width_t w, input logic [31:0] wd,
                                         output logic flt, output logic [31:0] rd,
                                         output int lat);
        int nb;
        int r;
        logic [31:0] a;
        nb  = (w == width_word) ? 4 : (w == width_halfword) ? 2 : 1;
        a   = addr;
        flt = 1'b0;
        rd  = 32'h0;
        if ((addr % 32'(nb)) != 0) begin
`ifdef MEMORY_ALIGN_CHECK_EN
            flt = 1'b1;
`endif
            a = addr - (addr % 32'(nb));
        end
        r = classify(a);
        if (r == 4) flt = 1'b1;
        if (wr && (r == 0 || r == 2)) flt = 1'b1;
        lat = (!wr && !flt && r == 0) ? 1 + ROM_WAIT : 1;
        if (!flt) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) wr_byte(a + 32'(i), wd[8*i +: 8]);
            end else begin
                for (int i = 0; i < 4; i++) rd[8*i +: 8] = rd_byte((a & ~32'h3) + 32'(i));
            end
        end
    endfunction

    // One complete transaction; call and return on a falling edge.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input access_width_t w,
                           input logic [31:0] wd, output logic [31:0] obs_rd, output logic obs_flt);
        logic        exp_flt;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          lat;
        logic [8:0]  rom_seen;
        model_access(addr, wr, w, wd, exp_flt, exp_rd, exp_lat);
        check_eq("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_width = w;
        bus.req_wdata = wd;
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom();
        bus.req_write = 1'($urandom());
        bus.req_wdata = $urandom();
        rom_seen = rom_addr;
        lat = 1;
        while (!bus.resp_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        obs_rd  = bus.resp_rdata;
        obs_flt = bus.resp_fault;
        check_eq("latency", lat, exp_lat);
        check_eq("rdata", obs_rd, exp_rd);
        check_eq("fault", obs_flt, exp_flt);
        if (exp_lat > 1) check_eq("rom_addr", rom_seen, addr[10:2]);
        @(negedge clock);
        check_eq("resp_done", bus.resp_valid, 1'b0);
        check_eq("out_mem", output_periph_mem, out_packed());
        n_txn++;
        $display("txn %0d: addr=%08h %s width=%0d wdata=%08h -> rdata=%08h fault=%0d lat=%0d",
                 n_txn, addr, wr ? "st" : "ld", w, wd, obs_rd, obs_flt, lat);
    endtask

    logic [31:0] bounds [12] = '{32'h0000, 32'h07FF, 32'h07FC, 32'h0800, 32'h0BFF, 32'h0C00,
                                 32'h0FFF, 32'h1000, 32'h100F, 32'h1010, 32'h180F, 32'h1810};

    initial begin
        logic [31:0]   rd;
        logic          flt;
        logic [31:0]   addr;
        logic [31:0]   bp_rd;
        logic          bp_flt;
        int            bp_lat;

        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_write  = 1'b0;
        bus.req_width  = width_word;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        input_periph_mem = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 512; i++) rom_model[i] = $urandom();
        rom_model[4] = 32'h12345678;
        for (int i = 0; i < 1024; i++) ram_model[i] = 8'h00;
        for (int i = 0; i < 16; i++) out_model[i] = 8'h00;

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_resp_valid", bus.resp_valid, 1'b0);
        check_eq("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check_eq("rst_resp_fault", bus.resp_fault, 1'b0);
        check_eq("rst_out_mem", output_periph_mem, 128'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("rst_req_ready", bus.req_ready, 1'b1);

        // Clear RAM so the model starts from known contents.
        for (int i = 0; i < 256; i++) run_txn(32'h0800 + 32'(4*i), 1'b1, width_word, 32'h0, rd, flt);

        // Byte store then word read
        run_txn(32'h0803, 1'b1, width_byte, 32'h000000A5, rd, flt);
        run_txn(32'h0800, 1'b0, width_word, 32'h0, rd, flt);
        check_eq("byte_store_word", rd, 32'hA5000000);

        // ROM read with wait states
        run_txn(32'h0010, 1'b0, width_word, 32'h0, rd, flt);
        check_eq("rom_read_word", rd, 32'h12345678);

        // Illegal accesses
        run_txn(32'h0004, 1'b1, width_word, 32'hFFFFFFFF, rd, flt);
        check_eq("st_rom_fault", flt, 1'b1);
        run_txn(32'h0004, 1'b0, width_word, 32'h0, rd, flt);
        check_eq("rom_untouched", rd, rom_model[1]);
        run_txn(32'h2000, 1'b0, width_word, 32'h0, rd, flt);
        check_eq("unmapped_fault", flt, 1'b1);
        check_eq("unmapped_rdata", rd, 32'h0);
        run_txn(32'h1000, 1'b1, width_byte, 32'h55, rd, flt);
        check_eq("st_in_fault", flt, 1'b1);

        // Misaligned word store
        run_txn(32'h0802, 1'b1, width_word, 32'h11223344, rd, flt);
        run_txn(32'h0800, 1'b0, width_word, 32'h0, rd, flt);
`ifdef MEMORY_ALIGN_CHECK_EN
        check_eq("misalign_ram", rd, 32'hA5000000);
`else
        check_eq("misalign_ram", rd, 32'h11223344);
`endif

        // Response backpressure with a competing request held on the bus
        run_txn(32'h1804, 1'b1, width_word, 32'h0BADF00D, rd, flt);
        begin
            logic        e_flt;
            logic [31:0] e_rd;
            model_access(32'h1804, 1'b0, width_word, 32'h0, e_flt, e_rd, bp_lat);
            bus.resp_ready = 1'b0;
            bus.req_valid  = 1'b1;
            bus.req_addr   = 32'h1804;
            bus.req_write  = 1'b0;
            bus.req_width  = width_word;
            @(negedge clock);
            bus.req_addr  = 32'h1808;
            bus.req_write = 1'b1;
            bus.req_wdata = 32'hCAFEF00D;
            for (int c = 0; c < 5; c++) begin
                bp_rd  = bus.resp_rdata;
                bp_flt = bus.resp_fault;
                check_eq("bp_valid", bus.resp_valid, 1'b1);
                check_eq("bp_rdata", bp_rd, e_rd);
                check_eq("bp_fault", bp_flt, e_flt);
                check_eq("bp_req_ready", bus.req_ready, 1'b0);
                check_eq("bp_out_mem", output_periph_mem, out_packed());
                @(negedge clock);
            end
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
            @(negedge clock);
            check_eq("bp_release", bus.resp_valid, 1'b0);
            check_eq("bp_not_taken", output_periph_mem, out_packed());
            n_txn++;
            $display("txn %0d: backpressure ld 00001804 held 5 cycles rdata=%08h", n_txn, bp_rd);
        end

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            if (t % 50 == 0) input_periph_mem = {$urandom(), $urandom(), $urandom(), $urandom()};
            case ($urandom_range(0, 5))
                0: addr = 32'($urandom_range(0, 2047));
                1: addr = 32'h0800 + 32'($urandom_range(0, 1023));
                2: addr = 32'h1000 + 32'($urandom_range(0, 15));
                3: addr = 32'h1800 + 32'($urandom_range(0, 15));
                4: addr = bounds[$urandom_range(0, 11)];
                default: addr = $urandom();
            endcase
            run_txn(addr, 1'($urandom()), access_width_t'($urandom_range(0, 2)), $urandom(), rd, flt);
        end

        // Reset one cycle after accepting an output store
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h1800;
        bus.req_write = 1'b1;
        bus.req_width = width_word;
        bus.req_wdata = 32'hDEADBEEF;
        @(negedge clock);
        bus.req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) out_model[i] = 8'h00;
        check_eq("midrst_out_mem", output_periph_mem[31:0], 32'h0);
        check_eq("midrst_resp_valid", bus.resp_valid, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("midrst_req_ready", bus.req_ready, 1'b1);
        check_eq("midrst_resp_idle", bus.resp_valid, 1'b0);
        run_txn(32'h1800, 1'b0, width_word, 32'h0, rd, flt);
        check_eq("midrst_readback", rd, 32'h0);
        n_txn++;
        $display("txn %0d: reset during store to 00001800", n_txn);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_bus.md
Name: memory_bus

Overview:
- Parametrised successor to the hart's flat memory decoder.
- Adds a valid/ready request and response handshake, configurable region bases and sizes, and ROM wait states.
- Adds byte-lane writes for every writable region, readable output peripherals, and fault reporting.
- Sits between the hart load/store unit and the ROM, RAM and memory-mapped peripheral banks.

Parameters:
- ROM_BYTES, 2048, ROM size; ROM occupies 0x0 .. ROM_BYTES-1.
- RAM_BASE, 32'h0800, first RAM byte address.
- RAM_BYTES, 1024, RAM size in bytes; power of two, multiple of 4.
- IN_BASE, 32'h1000, first input-peripheral byte address.
- INPUT_PERIPH_LEN, 16, input peripheral bytes; multiple of 4.
- OUT_BASE, 32'h1800, first output-peripheral byte address.
- OUTPUT_PERIPH_LEN, 16, output peripheral bytes; multiple of 4.
- ROM_WAIT, 2, extra cycles between ROM address issue and ROM data use; 0..15.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  XLEN  byte address.
- req_write  in  1  1 = store, 0 = load.
- req_width  in  access_width_t  byte / halfword / word.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  XLEN  aligned word containing req_addr; 0 on fault or store.
- resp_fault  out  1  access rejected.
- rom_addr  out  ROM word-index width  word index into the external ROM.
- rom_rdata  in  XLEN  ROM data.
- input_periph_mem  in  8 x INPUT_PERIPH_LEN  input peripheral bytes.
- output_periph_mem  out  8 x OUTPUT_PERIPH_LEN  output peripheral bytes.

Behaviour:
- Reset (asynchronous, while reset_n = 0):
  - state = S_IDLE; wait counter = 0.
  - resp_valid = 0, resp_rdata = 0, resp_fault = 0.
  - All output_periph_mem bytes = 0.
  - req_ready = 1 as soon as reset_n deasserts.
  - Reset asserted mid-transaction aborts it: no further write, response discarded.
- Region decode on the accepted address:
  - ROM: addr < ROM_BYTES.
  - RAM: RAM_BASE <= addr < RAM_BASE+RAM_BYTES.
  - IN: IN_BASE <= addr < IN_BASE+INPUT_PERIPH_LEN.
  - OUT: OUT_BASE <= addr < OUT_BASE+OUTPUT_PERIPH_LEN.
  - Anything else is unmapped and faults.
- State machine:
  - S_IDLE: req_ready = 1.
    - On accept (req_valid & req_ready), latch addr, write, width, wdata.
    - ROM read -> S_WAIT with counter = ROM_WAIT; if ROM_WAIT = 0, go directly to S_RESP after one cycle.
    - All other accesses -> S_RESP after exactly one cycle.
  - S_WAIT: counter decrements each cycle; at 0 -> S_RESP.
  - S_RESP: resp_valid = 1, req_ready = 0. Outputs hold stable until resp_ready = 1, then -> S_IDLE.
- Latency: 1 cycle from accept to resp_valid, or 1+ROM_WAIT cycles for ROM reads. No back-to-back overlap; throughput is at most one transaction per 2 cycles.
- Writes:
  - Byte strobes: byte = 1<<addr[1:0]; halfword = 2'b11<<{addr[1],1'b0}; word = 4'hF.
  - Lane data: wdata byte k goes to the strobed lane.
  - Written on the clock edge after accept.
  - RAM and OUT are writable.
  - A write to ROM or IN faults with no side effect.
- Reads:
  - Return the full aligned word (addr[1:0] ignored); the hart extracts the sub-word.
  - OUT reads return the current register value (never X).
- Fault: resp_fault = 1 and resp_rdata = 0; no state change in any memory.
- A request held on req_valid while req_ready = 0 is not consumed. Request inputs are sampled only at accept.

Optional Feature:
MEMORY_ALIGN_CHECK_EN:
- Defined: a halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, faults with no write.
- Undefined: the address is forced down to natural alignment, with no fault. A halfword at ...1 acts on ...0, and a word acts on addr & ~3.

Decomposition:
- Package memory_types:
  - access_width_t enum {width_byte, width_halfword, width_word}.
  - region_t enum {region_rom, region_ram, region_in, region_out, region_none}.
  - bus_state_t enum {S_IDLE, S_WAIT, S_RESP}.
  - Byte-strobe function.
- Sub-module ram_bytelane: RAM_BYTES deep, 4 byte lanes with per-lane write enable, registered read of the aligned word.

Test Plan:
- Reset mid-write: assert reset_n = 0 one cycle after accepting a word store of 32'hDEADBEEF to 0x1800 -> output_periph_mem[0..3] stay 0 and resp_valid = 0.
- Byte store then read: store byte 8'hA5 to 0x0803, then load word at 0x0800 -> resp_rdata = 32'hA5000000, fault = 0, resp_valid exactly 1 cycle after accept.
- ROM read, ROM_WAIT = 2: load 0x0010 with rom_rdata = 32'h12345678 -> rom_addr = 4, resp_valid 3 cycles after accept, rdata = 32'h12345678.
- Response backpressure: hold resp_ready = 0 for 5 cycles -> resp_valid, resp_rdata and resp_fault stable; req_ready = 0 throughout; a new req_valid is not accepted.
- Illegal accesses:
  - Store to 0x0004 -> fault = 1 with ROM untouched.
  - Load 0x2000 -> fault = 1 with rdata = 0.
  - Store to 0x1000 -> fault = 1.
- Misaligned word store of 32'h11223344 to 0x0802:
  - With MEMORY_ALIGN_CHECK_EN -> fault = 1 and RAM unchanged.
  - Without it -> word at 0x0800 = 32'h11223344.
